dco_tune_enc: RTL and testbench
===============================

DCO_TUNE_ENC -- requirements
Module: dco_tune_enc

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16: cycles between power-up and accepting tuning words.
REQ-002 SHALL have parameter N_L_MAX, default 25: large-bank cap count ceiling (5x5 array).
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  in  1  oscillator enable; 0 requests power-down.
REQ-006 SHALL have port gain_in  in  2  oscillator gain request.
REQ-007 SHALL have port tune_l / tune_m / tune_s  in  5/8/8  binary cap counts for the large/medium/small banks.
REQ-008 SHALL have port tune_frac  in  4  fractional small-bank word, unsigned, LSB = 1/16.
REQ-009 SHALL have port tune_valid  in  1, and tune_ready  out  1: the tuning-word handshake.
REQ-010 SHALL have port pd  out  1, and osc_gain  out  2: the DCO power-down and gain controls.
REQ-011 SHALL have ports c_l_rall/c_l_row/c_l_col  out  5 each: the large-bank row-all/row/column selects.
REQ-012 SHALL have ports c_m_rall/c_m_row/c_m_col and c_s_rall/c_s_row/c_s_col  out  16 each: the medium and small bank selects.
REQ-013 SHALL have port busy  out  1: high while outputs differ from the last accepted word.

Function
REQ-014 The DCO cell (i,j) is on iff rall[i] OR (row[i] AND col[j]); the encoder SHALL make the on-cell count equal the binary count N.
REQ-015 Encoding, array width W (5 or 16), q=N/W, r=N%W: rall[i]=1 for i<q; row[i]=1 only for i==q and q<W; col[j]=1 for j<r; all other bits 0.
REQ-016 tune_l values above N_L_MAX SHALL clamp to N_L_MAX; medium/small counts are full 0..255.
REQ-017 The FSM SHALL have three states: OFF (pd=1, tune_ready=0), SETTLE (pd=0, counting), and RUN (pd=0, tune_ready=1).
REQ-018 Transitions: OFF->SETTLE when en=1; SETTLE->RUN after SETTLE_CYC cycles; any state->OFF when en=0, with pd=1 on the next cycle.
REQ-019 A word SHALL be accepted only on tune_valid AND tune_ready; stage 1 registers it, stage 2 registers the encoded selects, so the outputs change exactly 2 cycles after acceptance.
REQ-020 All nine select buses SHALL update in the same cycle; no partial-bank update is permitted.
REQ-021 Back-to-back accepts SHALL pipeline, one word per cycle with no bubble.
REQ-022 busy SHALL be 1 from acceptance until the encoded word reaches the outputs.
REQ-023 When leaving RUN for OFF, the select buses SHALL hold their last value; an in-flight word SHALL be dropped.
REQ-024 osc_gain SHALL be gain_in registered once, and is sampled in every state.
REQ-025 The large/medium/small codes are cap counts; the DCO applies negative gain, so a larger count gives a lower frequency. The encoder does not invert.

Reset
REQ-026 On rst: state=OFF, pd=1, tune_ready=0, busy=0, osc_gain=0, all select buses 0, pipeline cleared, SDM accumulator 0, settle counter 0.
REQ-027 rst SHALL take priority over en and tune_valid in the same cycle; rst mid-pipeline SHALL discard the word.

Configuration
REQ-028 Macro DCO_TUNE_SDM_EN: when defined, a 4-bit first-order accumulator SHALL add tune_frac every RUN cycle. The carry SHALL be added to the accepted tune_s, saturating at 255, and the small-bank selects SHALL re-encode every cycle with 2-cycle latency.
REQ-029 Without DCO_TUNE_SDM_EN, tune_frac SHALL be ignored, no accumulator SHALL exist, and the small bank SHALL change only on accepted words.

Verification
REQ-030 rst, en=1 -> pd=0 one cycle later; tune_ready=1 after SETTLE_CYC=16 further cycles; all selects stay 0.
REQ-031 Accept tune_l=7 -> 2 cycles later c_l_rall=00001, c_l_row=00010, c_l_col=00011 (7 cells on).
REQ-032 Accept tune_m=200 and tune_l=30 -> c_m_rall=0x0FFF, c_m_row=0x1000, c_m_col=0x00FF; tune_l clamped to 25: c_l_rall=11111, row=0, col=0.
REQ-033 With SDM: tune_s=10, tune_frac=4, held for 16 RUN cycles -> small count 11 in exactly 4 cycles and 10 in 12; tune_s=255 with frac=15 -> count stays 255.
REQ-034 Accept a word, then en=0 the next cycle -> pd=1 the following cycle, selects unchanged, busy=0; rst during the same flow -> all outputs at reset values.
REQ-035 Three consecutive accepts of 1, 16, 255 on tune_m -> outputs show 1, 16, 255 on three consecutive cycles, starting 2 cycles after the first accept; for 16, c_m_rall=0x0001, row=0x0002, col=0.

Source files
------------

// File: rtl/dco_tune_enc.sv
// Tuning-word encoder for a three-bank DCO: power-up sequencing, 2-stage
// binary-to-thermometer select encoding. Optional small-bank dither: DCO_TUNE_SDM_EN.
module dco_tune_enc #(
  parameter int SETTLE_CYC = 16,
  parameter int N_L_MAX    = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  gain_in,
  input  logic [4:0]  tune_l,
  input  logic [7:0]  tune_m,
  input  logic [7:0]  tune_s,
  input  logic [3:0]  tune_frac,
  input  logic        tune_valid,
  output logic        tune_ready,
  output logic        pd,
  output logic [1:0]  osc_gain,
  output logic [4:0]  c_l_rall,
  output logic [4:0]  c_l_row,
  output logic [4:0]  c_l_col,
  output logic [15:0] c_m_rall,
  output logic [15:0] c_m_row,
  output logic [15:0] c_m_col,
  output logic [15:0] c_s_rall,
  output logic [15:0] c_s_row,
  output logic [15:0] c_s_col,
  output logic        busy
);

  typedef enum logic [1:0] {OFF, SETTLE, RUN} state_t;

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [4:0] L_MAX = 5'(N_L_MAX);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          load, run_en;
  logic          vld_p1;
  logic [4:0]    l_p1;
  logic [7:0]    m_p1;
  logic [7:0]    s_p1;

  function automatic logic [4:0] clamp_l(input logic [4:0] n);
    return (n > L_MAX) ? L_MAX : n;
  endfunction

  // Row-all covers whole rows below q, row q is partially filled via col.
  function automatic logic [14:0] enc5(input logic [4:0] n);
    logic [2:0] q, r;
    logic [4:0] rall, row, col;
    q    = 3'(n / 5'd5);
    r    = 3'(n % 5'd5);
    rall = 5'((6'd1 << q) - 6'd1);
    row  = (q < 3'd5) ? 5'(6'd1 << q) : 5'd0;
    col  = 5'((6'd1 << r) - 6'd1);
    return {rall, row, col};
  endfunction

  function automatic logic [47:0] enc16(input logic [7:0] n);
    logic [15:0] rall, row, col;
    rall = (16'd1 << n[7:4]) - 16'd1;
    row  = 16'd1 << n[7:4];
    col  = (16'd1 << n[3:0]) - 16'd1;
    return {rall, row, col};
  endfunction

  assign pd         = (state == OFF);
  assign tune_ready = (state == RUN);
  assign busy       = vld_p1;
  assign run_en     = (state == RUN) && en;
  assign load       = tune_valid && tune_ready && en;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!en) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RUN:     state_nxt = RUN;
        default: state_nxt = OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= OFF;
      cnt      <= '0;
      osc_gain <= 2'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      osc_gain <= gain_in;
    end
  end

  // Stage 1: capture accepted word (dropped if en falls the same cycle)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      l_p1   <= '0;
      m_p1   <= '0;
    end else begin
      vld_p1 <= load;
      if (load) begin
        l_p1 <= clamp_l(tune_l);
        m_p1 <= tune_m;
      end
    end
  end

  // Stage 2: all encoded selects land together
  always_ff @(posedge clk) begin
    if (rst) begin
      {c_l_rall, c_l_row, c_l_col} <= '0;
      {c_m_rall, c_m_row, c_m_col} <= '0;
    end else if (vld_p1 && en) begin
      {c_l_rall, c_l_row, c_l_col} <= enc5(l_p1);
      {c_m_rall, c_m_row, c_m_col} <= enc16(m_p1);
    end
  end

`ifdef DCO_TUNE_SDM_EN
  logic [3:0] acc;
  logic [4:0] acc_sum;
  logic [7:0] s_base, s_word;
  logic       s_vld_p1;

  function automatic logic [7:0] sat_inc(input logic [7:0] s, input logic c);
    return (c && (s != 8'hFF)) ? s + 8'd1 : s;
  endfunction

  assign acc_sum = {1'b0, acc} + {1'b0, tune_frac};
  assign s_word  = load ? tune_s : s_base;

  // Small bank re-evaluates every RUN cycle with the dither carry folded in.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      s_base   <= '0;
      s_p1     <= '0;
      s_vld_p1 <= 1'b0;
    end else begin
      s_vld_p1 <= run_en;
      if (run_en) begin
        acc    <= acc_sum[3:0];
        s_base <= s_word;
        s_p1   <= sat_inc(s_word, acc_sum[4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      {c_s_rall, c_s_row, c_s_col} <= '0;
    else if (s_vld_p1 && en)
      {c_s_rall, c_s_row, c_s_col} <= enc16(s_p1);
  end
`else
  logic unused_frac;
  logic unused_run;
  assign unused_frac = ^tune_frac;
  assign unused_run  = run_en;

  always_ff @(posedge clk) begin
    if (rst)
      s_p1 <= '0;
    else if (load)
      s_p1 <= tune_s;
  end

  always_ff @(posedge clk) begin
    if (rst)
      {c_s_rall, c_s_row, c_s_col} <= '0;
    else if (vld_p1 && en)
      {c_s_rall, c_s_row, c_s_col} <= enc16(s_p1);
  end
`endif

endmodule

// File: tb/tb_dco_tune_enc.sv
// Self-checking bench for dco_tune_enc: vector table plus scoreboard of expected
// on-cell counts, with hand sequences for sequencing, drop and reset corners.
module tb_dco_tune_enc;

  logic        clk = 1'b0;
  logic        rst, en, tune_valid;
  logic [1:0]  gain_in, osc_gain;
  logic [4:0]  tune_l;
  logic [7:0]  tune_m, tune_s;
  logic [3:0]  tune_frac;
  logic        tune_ready, pd, busy;
  logic [4:0]  c_l_rall, c_l_row, c_l_col;
  logic [15:0] c_m_rall, c_m_row, c_m_col, c_s_rall, c_s_row, c_s_col;
  logic [110:0] allsel, snap;

  assign allsel = {c_l_rall, c_l_row, c_l_col, c_m_rall, c_m_row, c_m_col,
                   c_s_rall, c_s_row, c_s_col};

  always #5 clk = ~clk;

  dco_tune_enc dut (
    .clk(clk), .rst(rst), .en(en), .gain_in(gain_in),
    .tune_l(tune_l), .tune_m(tune_m), .tune_s(tune_s), .tune_frac(tune_frac),
    .tune_valid(tune_valid), .tune_ready(tune_ready), .pd(pd), .osc_gain(osc_gain),
    .c_l_rall(c_l_rall), .c_l_row(c_l_row), .c_l_col(c_l_col),
    .c_m_rall(c_m_rall), .c_m_row(c_m_row), .c_m_col(c_m_col),
    .c_s_rall(c_s_rall), .c_s_row(c_s_row), .c_s_col(c_s_col),
    .busy(busy)
  );

  typedef struct { int due; int l; int m; int s; } exp_t;
  typedef struct { logic [4:0] l; logic [7:0] m; logic [7:0] s; int el; int em; int es; } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [110:0] act, input logic [110:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts lit cells straight from the cell equation of the array.
  function automatic int cells(input logic [15:0] rall, input logic [15:0] row,
                               input logic [15:0] col, input int w);
    int n = 0;
    for (int i = 0; i < w; i++)
      for (int j = 0; j < w; j++)
        if (rall[i] || (row[i] && col[j])) n++;
    return n;
  endfunction

  task automatic check_sb();
    exp_t e;
    int sc;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL sb_missed: word due at cycle %0d not checked by cycle %0d", sb[0].due, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("l_cells", cells({11'b0, c_l_rall}, {11'b0, c_l_row}, {11'b0, c_l_col}, 5), e.l);
      chk("m_cells", cells(c_m_rall, c_m_row, c_m_col, 16), e.m);
      sc = cells(c_s_rall, c_s_row, c_s_col, 16);
`ifdef DCO_TUNE_SDM_EN
      checks++;
      if (sc != e.s && sc != ((e.s == 255) ? 255 : e.s + 1)) begin
        errors++;
        $display("FAIL s_cells: got %0d expected %0d or +1", sc, e.s);
      end
`else
      chk("s_cells", sc, e.s);
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_sb();
  endtask

  task automatic send(input logic [4:0] l, input logic [7:0] m, input logic [7:0] s,
                      input int el, input bit track);
    exp_t e;
    tune_l = l;
    tune_m = m;
    tune_s = s;
    tune_valid = 1'b1;
    if (track && tune_ready) begin
      e = '{cyc + 2, el, int'(m), int'(s)};
      sb.push_back(e);
    end
    step();
    tune_valid = 1'b0;
  endtask

  task automatic settle_to_run();
    for (int i = 0; i < 17; i++) step();
    chk("ready_after_settle", tune_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n11, nbad;
    tbl[0] = '{5'd0,  8'd0,   8'd0,   0,  0,   0};
    tbl[1] = '{5'd25, 8'd255, 8'd255, 25, 255, 255};
    tbl[2] = '{5'd26, 8'd1,   8'd16,  25, 1,   16};
    tbl[3] = '{5'd31, 8'd16,  8'd15,  25, 16,  15};
    tbl[4] = '{5'd5,  8'd17,  8'd128, 5,  17,  128};
    tbl[5] = '{5'd4,  8'd100, 8'd1,   4,  100, 1};
    tbl[6] = '{5'd12, 8'd240, 8'd254, 12, 240, 254};
    tbl[7] = '{5'd24, 8'd15,  8'd31,  24, 15,  31};

    rst = 1'b1; en = 1'b0; tune_valid = 1'b0; gain_in = 2'b11;
    tune_l = '0; tune_m = '0; tune_s = '0; tune_frac = '0;
    step(); step();
    chk("rst_pd", pd, 1);
    chk("rst_ready", tune_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gain", osc_gain, 0);
    chk_wide("rst_sel", allsel, '0);

    rst = 1'b0; gain_in = 2'b01;
    step();
    chk("gain_in_off", osc_gain, 1);
    chk("pd_off_en0", pd, 1);

    en = 1'b1; gain_in = 2'b10;
    step();
    chk("pd_after_en", pd, 0);
    chk("gain_settle", osc_gain, 2);
    for (int i = 0; i < 15; i++) step();
    chk("ready_settle15", tune_ready, 0);
    step();
    chk("ready_settle16", tune_ready, 1);
    chk_wide("sel_zero_settle", allsel, '0);

    // Large bank 7 cells: one full row plus two columns of the next
    send(5'd7, 8'd0, 8'd0, 7, 1);
    chk("busy_inflight", busy, 1);
    chk("l_hold_1cyc", c_l_rall, 0);
    step();
    chk("l7_rall", c_l_rall, 5'b00001);
    chk("l7_row", c_l_row, 5'b00010);
    chk("l7_col", c_l_col, 5'b00011);
    chk("busy_done", busy, 0);

    send(5'd30, 8'd200, 8'd0, 25, 1);
    step();
    chk("m200_rall", c_m_rall, 16'h0FFF);
    chk("m200_row", c_m_row, 16'h1000);
    chk("m200_col", c_m_col, 16'h00FF);
    chk("l30_rall", c_l_rall, 5'b11111);
    chk("l30_row", c_l_row, 5'b00000);
    chk("l30_col", c_l_col, 5'b00000);

    for (int i = 0; i < 8; i++)
      send(tbl[i].l, tbl[i].m, tbl[i].s, tbl[i].el, 1);
    step(); step();
    chk("busy_after_burst", busy, 0);

    send(5'd0, 8'd1, 8'd0, 0, 1);
    send(5'd0, 8'd16, 8'd0, 0, 1);
    send(5'd0, 8'd255, 8'd0, 0, 1);
    chk("m16_rall", c_m_rall, 16'h0001);
    chk("m16_row", c_m_row, 16'h0002);
    chk("m16_col", c_m_col, 16'h0000);
    step();

    gain_in = 2'b11;
    step();
    chk("gain_run", osc_gain, 3);

    // Power-down right behind an accept: word must be dropped
    snap = allsel;
    send(5'd3, 8'd50, 8'd9, 3, 0);
    en = 1'b0;
    chk("busy_before_drop", busy, 1);
    step();
    chk("pd_drop", pd, 1);
    chk("busy_drop", busy, 0);
    chk_wide("sel_hold_drop", allsel, snap);
    step();
    chk_wide("sel_hold_off", allsel, snap);
    chk("ready_off", tune_ready, 0);

    en = 1'b1;
    settle_to_run();
    send(5'd3, 8'd50, 8'd9, 3, 0);
    rst = 1'b1; tune_valid = 1'b1;
    step();
    chk("rst_mid_pd", pd, 1);
    chk("rst_mid_ready", tune_ready, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_gain", osc_gain, 0);
    chk_wide("rst_mid_sel", allsel, '0);
    rst = 1'b0; tune_valid = 1'b0;
    step();
    chk("pd_after_rst", pd, 0);
    step();
    chk_wide("sel_stay_zero", allsel, '0);

`ifdef DCO_TUNE_SDM_EN
    settle_to_run();
    tune_frac = 4'd4;
    send(5'd0, 8'd0, 8'd10, 0, 0);
    n11 = 0; nbad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (cells(c_s_rall, c_s_row, c_s_col, 16) == 11) n11++;
      else if (cells(c_s_rall, c_s_row, c_s_col, 16) != 10) nbad++;
    end
    chk("sdm_frac4_high", n11, 4);
    chk("sdm_frac4_other", nbad, 0);
    tune_frac = 4'd15;
    send(5'd0, 8'd0, 8'd255, 0, 0);
    nbad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (cells(c_s_rall, c_s_row, c_s_col, 16) != 255) nbad++;
    end
    chk("sdm_sat255", nbad, 0);
    tune_frac = 4'd0;
`endif

    step(); step(); step();
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
